// File: rtl/udp_sweep_ctrl.sv
// Self-check sequencer for a 3-input logic cell: sweeps {x,y,z} over 000..111,
// samples f after a settle time per vector and compares the truth table with an expected one.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; results from the last sweep held
// SETTLE | vector idx driven on {x,y,z}, settle timer running
// SAMPLE | f_in captured into tt[idx]; advance to next vector or finish
// DONE   | compare tt with captured expectation, pulse done
module udp_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       f_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle timer is a down-counter: loaded with SETTLE_CYCLES-1, SAMPLE follows terminal count 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [2:0] idx;
    logic [7:0] exp_q;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            idx        <= 3'd0;
            exp_q      <= 8'h00;
            {x, y, z}  <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt         <= 8'h00;
            fail_idx   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    {x, y, z} <= 3'b000;
                    if (start) begin
                        exp_q      <= exp_tt;
                        idx        <= 3'd0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        tt         <= 8'h00;
                        fail_idx   <= 3'd0;
                        state      <= SETTLE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    tt[idx] <= f_in;
                    if (idx == 3'd7) begin
                        // Release the cell inputs now so vector 7 is held no longer than the others.
                        {x, y, z} <= 3'b000;
                        state     <= DONE;
                    end else begin
                        idx        <= idx + 3'd1;
                        {x, y, z}  <= idx + 3'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    pass     <= (tt == exp_q);
                    fail_idx <= lowest_set(tt ^ exp_q);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_sweep_ctrl.sv
// Bench for udp_sweep_ctrl: three instances (settle 2, 1, 15) checked cycle by cycle
// against a per-cycle timing model and a truth-table model of the attached cell.
module tb_udp_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [3];
    logic [7:0] exp_in;
    logic       f_v     [3];
    logic       x_o     [3];
    logic       y_o     [3];
    logic       z_o     [3];
    logic       busy_o  [3];
    logic       done_o  [3];
    logic       pass_o  [3];
    logic [7:0] tt_o    [3];
    logic [2:0] fi_o    [3];

    int mode;
    int cyc;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    udp_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .exp_tt(exp_in), .f_in(f_v[0]),
        .x(x_o[0]), .y(y_o[0]), .z(z_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .tt(tt_o[0]), .fail_idx(fi_o[0]));

    udp_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .exp_tt(exp_in), .f_in(f_v[1]),
        .x(x_o[1]), .y(y_o[1]), .z(z_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .tt(tt_o[1]), .fail_idx(fi_o[1]));

    udp_sweep_ctrl #(.SETTLE_CYCLES(15)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .exp_tt(exp_in), .f_in(f_v[2]),
        .x(x_o[2]), .y(y_o[2]), .z(z_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .tt(tt_o[2]), .fail_idx(fi_o[2]));

    function automatic int s_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Cell models: 0 = parity, 1 = majority, 2 = f stuck at 1 except the idx-2 sample cycle.
    function automatic logic cell_f(input int md, input logic [2:0] v, input int c, input int s);
        case (md)
            0:       return ($countones(v) % 2) == 1;
            1:       return $countones(v) >= 2;
            default: return (c == 2 * (s + 1) + s) ? 1'b0 : 1'b1;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            f_v[i] = cell_f(mode, {x_o[i], y_o[i], z_o[i]}, cyc, s_of(i));
        end
    end

    function automatic logic [7:0] model_tt(input int md);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) t[i] = cell_f(md, 3'(i), -1, 0);
        return t;
    endfunction

    function automatic logic [2:0] model_fi(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (a[i] != b[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic chk_idle_reset(input int k);
        chk("rst_xyz", {29'd0, x_o[k], y_o[k], z_o[k]}, 0);
        chk("rst_busy", busy_o[k], 0);
        chk("rst_done", done_o[k], 0);
        chk("rst_pass", pass_o[k], 0);
        chk("rst_tt", tt_o[k], 0);
        chk("rst_fail_idx", fi_o[k], 0);
    endtask

    // Full sweep on instance k, called just after a falling edge; rp_a/rp_b are
    // cycles in which start is re-pulsed (negative = none).
    task automatic sweep(input int k, input logic [7:0] expv, input int md, input int rp_a,
                         input int rp_b, input logic [7:0] e_tt, input logic e_pass,
                         input logic [2:0] e_fi);
        int s;
        int per;
        int lat;
        int vec;
        s   = s_of(k);
        per = s + 1;
        lat = 8 * per + 1;
        mode       = md;
        exp_in     = expv;
        cyc        = -1;
        start_v[k] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            cyc        = c;
            start_v[k] = (c == rp_a) || (c == rp_b);
            exp_in     = expv ^ 8'(c);
            vec        = (c < 8 * per) ? c / per : 0;
            chk("xyz", {29'd0, x_o[k], y_o[k], z_o[k]}, vec);
            chk("busy", busy_o[k], c <= lat);
            chk("done", done_o[k], c == lat);
            if (c == 0) begin
                chk("tt_cleared", tt_o[k], 0);
                chk("pass_cleared", pass_o[k], 0);
            end
            if (c >= lat) begin
                chk("tt", tt_o[k], e_tt);
                chk("pass", pass_o[k], e_pass);
                chk("fail_idx", fi_o[k], e_fi);
            end
        end
        start_v[k] = 1'b0;
        cyc        = -1;
    endtask

    typedef struct {
        int         k;
        logic [7:0] expv;
        int         md;
        int         rp_a;
        int         rp_b;
        logic [7:0] e_tt;
        logic       e_pass;
        logic [2:0] e_fi;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [7:0] e;
        logic [7:0] mt;
        int         md;
        int         lat;
        logic       seen;

        tbl[0] = '{k: 0, expv: 8'h96, md: 0, rp_a: -1, rp_b: -1, e_tt: 8'h96, e_pass: 1'b1, e_fi: 3'd0};
        tbl[1] = '{k: 0, expv: 8'h96, md: 1, rp_a: -1, rp_b: -1, e_tt: 8'hE8, e_pass: 1'b0, e_fi: 3'd1};
        tbl[2] = '{k: 0, expv: 8'h96, md: 0, rp_a: 5,  rp_b: 24, e_tt: 8'h96, e_pass: 1'b1, e_fi: 3'd0};
        tbl[3] = '{k: 1, expv: 8'hE8, md: 1, rp_a: -1, rp_b: -1, e_tt: 8'hE8, e_pass: 1'b1, e_fi: 3'd0};
        tbl[4] = '{k: 2, expv: 8'h00, md: 0, rp_a: -1, rp_b: -1, e_tt: 8'h96, e_pass: 1'b0, e_fi: 3'd1};
        tbl[5] = '{k: 0, expv: 8'hFF, md: 2, rp_a: -1, rp_b: -1, e_tt: 8'hFB, e_pass: 1'b0, e_fi: 3'd2};

        rst    = 1'b1;
        mode   = 0;
        cyc    = -1;
        exp_in = 8'h00;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle_reset(i);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            sweep(tbl[t].k, tbl[t].expv, tbl[t].md, tbl[t].rp_a, tbl[t].rp_b,
                  tbl[t].e_tt, tbl[t].e_pass, tbl[t].e_fi);
        end

        for (int r = 0; r < 6; r++) begin
            e  = 8'($urandom);
            md = int'($urandom_range(0, 1));
            mt = model_tt(md);
            sweep(0, e, md, int'($urandom_range(1, 24)), -1, mt, mt == e, model_fi(mt, e));
        end

        // Reset during the first settle cycle of vector 4 aborts without a done pulse.
        mode       = 0;
        exp_in     = 8'h96;
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            cyc        = c;
            start_v[0] = 1'b0;
        end
        chk("pre_abort_xyz", {29'd0, x_o[0], y_o[0], z_o[0]}, 4);
        chk("pre_abort_tt", tt_o[0], 8'h06);
        rst = 1'b1;
        #1;
        chk_idle_reset(0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done_o[0];
        end
        chk("abort_no_done", seen, 0);
        rst = 1'b0;
        cyc = -1;
        @(negedge clk);
        sweep(0, 8'h96, 0, -1, -1, 8'h96, 1'b1, 3'd0);

        // start held high: a new sweep follows immediately after done.
        lat        = 8 * 3 + 1;
        exp_in     = 8'hE8;
        mode       = 1;
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == lat) begin
                chk("held_done", done_o[0], 1);
                chk("held_tt", tt_o[0], 8'hE8);
            end
        end
        chk("held_restart_busy", busy_o[0], 1);
        chk("held_restart_done", done_o[0], 0);
        chk("held_restart_tt", tt_o[0], 0);
        start_v[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2 * lat && !seen; c++) begin
            @(negedge clk);
            seen = done_o[0];
        end
        chk("held_second_done", seen, 1);
        chk("held_second_pass", pass_o[0], 1);
        @(negedge clk);
        chk("held_final_busy", busy_o[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
